// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with synchronous clear, sanitising parallel
// load, wrap or saturate at the terminal values, and registered event pulses.
module bcd_updown_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [1:0]   rst_sync;
    logic         rst_hold;
    logic [W-1:0] count;
    logic [W-1:0] count_nxt;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] clean_val;
    logic         carry;
    logic         borrow;
    logic         all9;
    logic         all0;
    logic         bad_digit;
    logic         ovf_nxt;
    logic         load_err_nxt;

    // Reset release is re-timed to clk; assertion stays asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst_hold = rst_sync[1];

    // Per-digit ripple of carry/borrow, terminal detection and load sanitising.
    always_comb begin
        inc_val   = count;
        dec_val   = count;
        clean_val = load_val;
        carry     = 1'b1;
        borrow    = 1'b1;
        all9      = 1'b1;
        all0      = 1'b1;
        bad_digit = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (count[4*k +: 4] != 4'd9) all9 = 1'b0;
            if (count[4*k +: 4] != 4'd0) all0 = 1'b0;
            if (carry) begin
                if (count[4*k +: 4] == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = count[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*k +: 4] == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end else begin
                    dec_val[4*k +: 4] = count[4*k +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
            if (load_val[4*k +: 4] > 4'd9) begin
                clean_val[4*k +: 4] = 4'd9;
                bad_digit           = 1'b1;
            end
        end
    end

    // Operation select: clr > load > en; losing operations raise no flag.
    always_comb begin
        count_nxt    = count;
        ovf_nxt      = 1'b0;
        load_err_nxt = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt    = clean_val;
            load_err_nxt = bad_digit;
        end else if (en) begin
            if (up) begin
                ovf_nxt   = all9;
                count_nxt = (all9 && SATURATE) ? count : inc_val;
            end else begin
                ovf_nxt   = all0;
                count_nxt = (all0 && SATURATE) ? count : dec_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else if (rst_hold) begin
            count    <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            ovf      <= ovf_nxt;
            load_err <= load_err_nxt;
        end
    end

    assign bcd_out = count;
    assign at_max  = all9;
    assign at_min  = all0;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: wrap and saturate instances share
// stimulus and are checked against an integer decimal model.
module tb_bcd_updown_counter;

    localparam int MAXV = 9999;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
        logic        err;
        logic        amax;
        logic        amin;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, up, clr, load;
    logic [15:0] load_val;
    logic [15:0] bcd0, bcd1;
    logic        ovf0, ovf1, max0, max1, min0, min1, err0, err1;

    exp_t q0[$];
    exp_t q1[$];
    int   mv[2];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bcd_out(bcd0), .ovf(ovf0), .at_max(max0),
        .at_min(min0), .load_err(err0)
    );

    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .bcd_out(bcd1), .ovf(ovf1), .at_max(max1),
        .at_min(min1), .load_err(err1)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Drive one cycle of inputs and queue the expected post-edge state.
    task automatic apply(input bit e, input bit u, input bit c, input bit l,
                         input logic [15:0] lv);
        en = e; up = u; clr = c; load = l; load_val = lv;
        for (int i = 0; i < 2; i++) begin
            exp_t x;
            x = '0;
            if (c) begin
                mv[i] = 0;
            end else if (l) begin
                int v;
                int d;
                v = 0;
                for (int k = 3; k >= 0; k--) begin
                    d = int'(lv[4*k +: 4]);
                    if (d > 9) begin
                        d = 9;
                        x.err = 1'b1;
                    end
                    v = v * 10 + d;
                end
                mv[i] = v;
            end else if (e) begin
                if (u) begin
                    if (mv[i] == MAXV) begin
                        x.ovf = 1'b1;
                        if (i == 0) mv[i] = 0;
                    end else begin
                        mv[i] = mv[i] + 1;
                    end
                end else begin
                    if (mv[i] == 0) begin
                        x.ovf = 1'b1;
                        if (i == 0) mv[i] = MAXV;
                    end else begin
                        mv[i] = mv[i] - 1;
                    end
                end
            end
            x.bcd  = to_bcd(mv[i]);
            x.amax = (mv[i] == MAXV);
            x.amin = (mv[i] == 0);
            if (i == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle();
    endtask

    // Monitor: every post-edge sample is compared against the queued model state.
    initial begin
        exp_t g0, g1, x0, x1;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0 && q1.size() > 0) begin
                x0 = q0.pop_front();
                x1 = q1.pop_front();
                g0 = '{bcd: bcd0, ovf: ovf0, err: err0, amax: max0, amin: min0};
                g1 = '{bcd: bcd1, ovf: ovf1, err: err1, amax: max1, amin: min1};
                checks += 2;
                if (g0 !== x0) begin
                    failures++;
                    $display("FAIL wrap t=%0t: got bcd=%h ovf=%b err=%b max=%b min=%b required bcd=%h ovf=%b err=%b max=%b min=%b",
                             $time, g0.bcd, g0.ovf, g0.err, g0.amax, g0.amin,
                             x0.bcd, x0.ovf, x0.err, x0.amax, x0.amin);
                end
                if (g1 !== x1) begin
                    failures++;
                    $display("FAIL sat t=%0t: got bcd=%h ovf=%b err=%b max=%b min=%b required bcd=%h ovf=%b err=%b max=%b min=%b",
                             $time, g1.bcd, g1.ovf, g1.err, g1.amax, g1.amin,
                             x1.bcd, x1.ovf, x1.err, x1.amax, x1.amin);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lv;
        int          r;
        rst = 1'b1; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        mv[0] = 0;
        mv[1] = 0;
        repeat (2) @(negedge clk);
        check_bit("reset_min", min0, 1'b1);
        check_bit("reset_bcd_zero", (bcd0 == 16'h0) && (bcd1 == 16'h0), 1'b1);
        release_reset();

        // Count to 0123, then reset asynchronously between edges.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0120);
        repeat (3) apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        mv[0] = 0;
        mv[1] = 0;
        #1;
        check_bit("async_rst_bcd", (bcd0 == 16'h0) && (bcd1 == 16'h0), 1'b1);
        check_bit("async_rst_ovf", ovf0 | ovf1, 1'b0);
        check_bit("async_rst_at_min", min0 & min1, 1'b1);
        release_reset();

        // Carry ripple, terminal up in both modes, borrow ripple, terminal down.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0999);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        idle();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
        repeat (3) apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        idle();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        repeat (2) apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        idle();

        // Sanitising load and priority between clr, load and en.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h12A4);
        idle();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 16'h9999);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        idle();

        // Random operations, with terminal-value loads to exercise wrap/saturate.
        for (int n = 0; n < 10000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                apply(1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 16'($urandom));
            end else if (r < 14) begin
                case ($urandom_range(0, 3))
                    0: lv = 16'h9999;
                    1: lv = 16'h0000;
                    2: lv = 16'($urandom);
                    default: lv = to_bcd(int'($urandom_range(0, MAXV)));
                endcase
                apply(1'($urandom), 1'($urandom), 1'b0, 1'b1, lv);
            end else if (r < 80) begin
                apply(1'b1, ($urandom_range(0, 99) < 55), 1'b0, 1'b0, 16'($urandom));
            end else begin
                apply(1'b0, 1'($urandom), 1'b0, 1'b0, 16'($urandom));
            end
        end
        idle();
        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d pending entries required 0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
